// File: rtl/jtag_multi_dr.sv
// JTAG slave: 16-state TAP, IR_W-bit instruction register, per-instruction DR mux (BYPASS/IDCODE/SAMPLE/USERk).
// Define JTAG_IDCODE_EN to build the IDCODE register; otherwise opcode 1 decodes as BYPASS and reset selects BYPASS.
module jtag_multi_dr #(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 8,
    parameter int          N_USER     = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input  logic                     i_tclk,
    input  logic                     i_trst_n,
    input  logic                     i_tms,
    input  logic                     i_tdi,
    output logic                     o_tdo,
    input  logic [DR_W-1:0]          i_bsr,
    output logic [N_USER*DR_W-1:0]   o_userData,
    output logic [N_USER-1:0]        o_userUpdate,
    output logic [IR_W-1:0]          o_irActive
);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RESET = IR_W'(1);
    localparam int              SH_W     = (DR_W > 32) ? DR_W : 32;
`else
    localparam logic [IR_W-1:0] IR_RESET = '1;
    localparam int              SH_W     = DR_W;
`endif
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_SMP, SEL_USR} dr_sel_e;

    tap_e                   state_q, state_d;
    logic [IR_W-1:0]        ir_sh_q, ir_sh_d;
    logic [IR_W-1:0]        ir_act_q, ir_act_d;
    logic [SH_W-1:0]        dr_q, dr_d;
    logic                   byp_q, byp_d;
    logic [N_USER*DR_W-1:0] user_q, user_d;
    logic [N_USER-1:0]      upd_q, upd_d;
    logic                   tdo_q, tdo_d;

    dr_sel_e                sel;
    logic [N_USER-1:0]      user_hit;
    logic [DR_W-1:0]        user_cap;

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            state_q  <= TLR;
            ir_sh_q  <= '0;
            ir_act_q <= IR_RESET;
            dr_q     <= '0;
            byp_q    <= 1'b0;
            user_q   <= '0;
            upd_q    <= '0;
            tdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_sh_q  <= ir_sh_d;
            ir_act_q <= ir_act_d;
            dr_q     <= dr_d;
            byp_q    <= byp_d;
            user_q   <= user_d;
            upd_q    <= upd_d;
            tdo_q    <= tdo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = i_tms ? TLR    : RTI;
            RTI:    state_d = i_tms ? SEL_DR : RTI;
            SEL_DR: state_d = i_tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = i_tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = i_tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = i_tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = i_tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = i_tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = i_tms ? SEL_DR : RTI;
            SEL_IR: state_d = i_tms ? TLR    : CAP_IR;
            CAP_IR: state_d = i_tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = i_tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = i_tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = i_tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = i_tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = i_tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Instruction decode; unknown opcodes fall through to BYPASS.
    always_comb begin
        user_hit = '0;
        user_cap = '0;
        for (int k = 0; k < N_USER; k++) begin
            if (ir_act_q == IR_W'(4 + k)) begin
                user_hit[k] = 1'b1;
                user_cap    = user_q[k*DR_W +: DR_W];
            end
        end
        sel = SEL_BYP;
        if (ir_act_q == IR_W'(2)) sel = SEL_SMP;
`ifdef JTAG_IDCODE_EN
        if (ir_act_q == IR_W'(1)) sel = SEL_ID;
`endif
        if (|user_hit) sel = SEL_USR;
    end

    // Register actions fire on the edge that leaves the named state.
    always_comb begin
        ir_sh_d  = ir_sh_q;
        ir_act_d = ir_act_q;
        dr_d     = dr_q;
        byp_d    = byp_q;
        user_d   = user_q;
        upd_d    = '0;
        unique case (state_q)
            CAP_IR: ir_sh_d = IR_CAPTURE;
            SH_IR:  ir_sh_d = {i_tdi, ir_sh_q[IR_W-1:1]};
            UPD_IR: ir_act_d = ir_sh_q;
            CAP_DR: begin
                unique case (sel)
                    SEL_ID:  dr_d = SH_W'(IDCODE_VAL);
                    SEL_SMP: dr_d = SH_W'(i_bsr);
                    SEL_USR: dr_d = SH_W'(user_cap);
                    default: byp_d = 1'b0;
                endcase
            end
            SH_DR: begin
                if (sel == SEL_BYP) begin
                    byp_d = i_tdi;
                end else begin
                    dr_d = dr_q >> 1;
`ifdef JTAG_IDCODE_EN
                    if (sel == SEL_ID) dr_d[31] = i_tdi;
                    else               dr_d[DR_W-1] = i_tdi;
`else
                    dr_d[DR_W-1] = i_tdi;
`endif
                end
            end
            UPD_DR: begin
                for (int k = 0; k < N_USER; k++) begin
                    if (user_hit[k]) begin
                        user_d[k*DR_W +: DR_W] = dr_q[DR_W-1:0];
                        upd_d[k]               = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == TLR) ir_act_d = IR_RESET;

        tdo_d = 1'b0;
        if (state_d == SH_IR)      tdo_d = ir_sh_d[0];
        else if (state_d == SH_DR) tdo_d = (sel == SEL_BYP) ? byp_d : dr_d[0];
    end

    assign o_tdo        = tdo_q;
    assign o_userData   = user_q;
    assign o_userUpdate = upd_q;
    assign o_irActive   = ir_act_q;

endmodule

// File: tb/tb_jtag_multi_dr.sv
// Directed bench for jtag_multi_dr: TAP walks, IR loads, and DR scans with hand-computed TDO streams.
// Expectations follow JTAG_IDCODE_EN the same way the design does.
module tb_jtag_multi_dr;
    localparam int IR_W   = 4;
    localparam int DR_W   = 8;
    localparam int N_USER = 2;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = 4'h1;
`else
    localparam logic [IR_W-1:0] IR_RST = 4'hF;
`endif

    logic                   clk = 1'b0;
    logic                   trst_n;
    logic                   tms;
    logic                   tdi;
    logic                   tdo;
    logic [DR_W-1:0]        bsr;
    logic [N_USER*DR_W-1:0] udata;
    logic [N_USER-1:0]      uupd;
    logic [IR_W-1:0]        iract;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] d;
    logic        b;

    jtag_multi_dr #(.IR_W(IR_W), .DR_W(DR_W), .N_USER(N_USER), .IDCODE_VAL(32'h1234_5679)) dut (
        .i_tclk      (clk),
        .i_trst_n    (trst_n),
        .i_tms       (tms),
        .i_tdi       (tdi),
        .o_tdo       (tdo),
        .i_bsr       (bsr),
        .o_userData  (udata),
        .o_userUpdate(uupd),
        .o_irActive  (iract)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive TMS/TDI for one TCK; returns TDO as seen during that cycle.
    task automatic step(input logic t, input logic di, output logic o);
        @(negedge clk);
        tms = t;
        tdi = di;
        o   = tdo;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic t);
        logic o;
        step(t, 1'b0, o);
    endtask

    task automatic scan(input int n, input logic [63:0] din, input logic last_exit, output logic [63:0] dout);
        logic o;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(last_exit && (i == n - 1), din[i], o);
            dout[i] = o;
        end
    endtask

    task automatic to_shift_dr;
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
    endtask

    task automatic update_dr;
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic load_ir(input logic [IR_W-1:0] v);
        logic [63:0] cap;
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        scan(IR_W, 64'(v), 1'b1, cap);
        chk("ir_capture", 64'(cap[IR_W-1:0]), 64'h1);
        update_dr;
        chk("ir_active", 64'(iract), 64'(v));
    endtask

    initial begin
        trst_n = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        bsr    = 8'h3C;
        #12;
        chk("rst_tdo", 64'(tdo), 64'h0);
        chk("rst_ir", 64'(iract), 64'(IR_RST));
        chk("rst_udata", 64'(udata), 64'h0);
        chk("rst_strobe", 64'(uupd), 64'h0);
        @(negedge clk);
        trst_n = 1'b1;

        repeat (5) idle(1'b1);
        chk("tlr_ir", 64'(iract), 64'(IR_RST));
        idle(1'b0);
        to_shift_dr;
        scan(32, 64'hCAFE_F00D, 1'b1, d);
`ifdef JTAG_IDCODE_EN
        chk("idcode_stream", d, 64'h1234_5679);
`else
        chk("reset_bypass32", d, 64'h95FD_E01A);
`endif
        update_dr;
        chk("no_strobe_first_dr", 64'(uupd), 64'h0);

        load_ir(4'hF);
        to_shift_dr;
        scan(4, 64'hD, 1'b1, d);
        chk("bypass_delay", d, 64'hA);
        update_dr;

        load_ir(4'h4);
        to_shift_dr;
        scan(8, 64'hA5, 1'b1, d);
        chk("user0_capture", d, 64'h0);
        update_dr;
        chk("user0_data", 64'(udata), 64'h00A5);
        chk("user0_strobe", 64'(uupd), 64'h1);
        idle(1'b0);
        chk("strobe_one_cycle", 64'(uupd), 64'h0);

        load_ir(4'h2);
        to_shift_dr;
        scan(8, 64'h0, 1'b1, d);
        chk("sample_stream", d, 64'h3C);
        update_dr;
        chk("sample_no_data", 64'(udata), 64'h00A5);
        chk("sample_no_strobe", 64'(uupd), 64'h0);

        load_ir(4'h5);
        to_shift_dr;
        scan(4, 64'h6, 1'b1, d);
        idle(1'b0);
        step(1'b0, 1'b0, b);
        chk("pause_tdo", 64'(b), 64'h0);
        idle(1'b1);
        idle(1'b0);
        scan(4, 64'h9, 1'b1, d);
        update_dr;
        chk("user1_data", 64'(udata), 64'h96A5);
        chk("user1_strobe", 64'(uupd), 64'h2);
        to_shift_dr;
        scan(8, 64'h96, 1'b1, d);
        chk("user1_recapture", d, 64'h96);
        update_dr;

        load_ir(4'h3);
        to_shift_dr;
        scan(3, 64'h3, 1'b1, d);
        chk("undef_bypass", d, 64'h6);
        update_dr;

        load_ir(4'h1);
        to_shift_dr;
        scan(4, 64'h6, 1'b1, d);
`ifdef JTAG_IDCODE_EN
        chk("op1_stream", d, 64'h9);
`else
        chk("op1_stream", d, 64'hC);
`endif
        update_dr;

        load_ir(4'h4);
        repeat (5) idle(1'b1);
        chk("tms_reset_ir", 64'(iract), 64'(IR_RST));
        idle(1'b0);

        load_ir(4'h4);
        to_shift_dr;
        scan(3, 64'h7, 1'b0, d);
        #2;
        trst_n = 1'b0;
        #1;
        chk("async_udata", 64'(udata), 64'h0);
        chk("async_ir", 64'(iract), 64'(IR_RST));
        chk("async_tdo", 64'(tdo), 64'h0);
        chk("async_strobe", 64'(uupd), 64'h0);
        @(negedge clk);
        trst_n = 1'b1;
        idle(1'b0);
        to_shift_dr;
        scan(4, 64'hF, 1'b1, d);
`ifdef JTAG_IDCODE_EN
        chk("post_reset_dr", d, 64'h9);
`else
        chk("post_reset_dr", d, 64'hE);
`endif
        update_dr;
        chk("post_reset_no_strobe", 64'(uupd), 64'h0);
        chk("post_reset_udata", 64'(udata), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
